// File: rtl/spi_pkg.sv
// Purpose : shared command codes, message-state encoding and sizing for the SPI slave link.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

  // Command byte values understood by the command-register block.
  localparam logic [7:0] CMD_RESET           = 8'h01;
  localparam logic [7:0] CMD_FORCE_TURBO     = 8'h02;
  localparam logic [7:0] CMD_SET_KEYB_MATRIX = 8'h10;
  localparam logic [7:0] CMD_SET_HCTRL       = 8'h11;
  localparam logic [7:0] CMD_WRITE_KBBUF     = 8'h12;
  localparam logic [7:0] CMD_SET_VIDMODE     = 8'h40;

  // Data bytes captured per message; anything beyond is ignored.
  localparam int MAX_DATA_BYTES = 8;

  typedef enum logic [2:0] {
    ST_WAIT_DESEL = 3'd0,
    ST_IDLE       = 3'd1,
    ST_CMD        = 3'd2,
    ST_DATA       = 3'd3,
    ST_OVERFLOW   = 3'd4
  } msg_state_e;

endpackage

// File: rtl/spi_slave_if_sync_edge.sv
// Purpose : multi-stage synchroniser with one history flop producing rise/fall pulses.
// Latency : STAGES clk to dout, edge pulses valid in the same cycle dout changes.
// Backpressure: none; free-running sampler.
// Ports   : clk, reset (async, active-high), din (async input),
//           dout (synchronised level), rise / fall (one-clk edge pulses).
module spi_sync_edge #(
  parameter int       STAGES  = 2,     // must be >= 2
  parameter bit       RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~hist_q;
  assign fall = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_slave_if.sv
// Purpose : SPI mode-0 slave; deserialises cmd + up to 8 data bytes, serialises spi_txdata on MISO.
// Latency : spi_msg_end at most SYNC_STAGES+2 clk after pin-level ssel_n rise.
// Backpressure: none; the host owns the link, excess data bytes are dropped.
// Ports   : clk, reset (async, active-high); spi_sclk/spi_ssel_n/spi_mosi pins in,
//           spi_miso out; spi_cmd/spi_rxdata/spi_msg_end to the command decoder;
//           spi_txdata/spi_txdata_valid response word from the command block.
module spi_slave_if
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_sclk,
  input  logic        spi_ssel_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_msg_end,
  output logic [7:0]  spi_cmd,
  output logic [63:0] spi_rxdata,
  input  logic [63:0] spi_txdata,
  input  logic        spi_txdata_valid
);

  // ---------------------------------------------------------------------------
  // Pin synchronisation
  // ---------------------------------------------------------------------------
  logic sclk_lvl_unused;
  logic sclk_rise, sclk_fall;
  logic ssel_lvl, ssel_rise, ssel_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (spi_sclk),
    .dout  (sclk_lvl_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // Reset value 0 ("selected") so a message already in flight at reset release
  // is never mistaken for a fresh ssel_n fall: WAIT_DESEL needs a real high.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ssel_sync (
    .clk   (clk),
    .reset (reset),
    .din   (spi_ssel_n),
    .dout  (ssel_lvl),
    .rise  (ssel_rise),
    .fall  (ssel_fall)
  );

  // mosi gets the same depth as sclk so the synced bit lines up with the
  // detected sclk rise.
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;

  always_comb mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mosi_sync_q <= '0;
    else       mosi_sync_q <= mosi_sync_d;
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // sclk edges only count while selected.
  logic sclk_rise_v, sclk_fall_v;
  assign sclk_rise_v = sclk_rise & ~ssel_lvl;
  assign sclk_fall_v = sclk_fall & ~ssel_lvl;

  // ---------------------------------------------------------------------------
  // Message state machine
  // ---------------------------------------------------------------------------
  msg_state_e  state_q,    state_d;
  logic [2:0]  bitcnt_q,   bitcnt_d;
  logic [3:0]  bytecnt_q,  bytecnt_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [63:0] tx_shift_q, tx_shift_d;
  logic [7:0]  cmd_q,      cmd_d;
  logic [63:0] rxdata_q,   rxdata_d;
  logic        cmd_seen_q, cmd_seen_d;
  logic        miso_q,     miso_d;
  logic        msg_end_q,  msg_end_d;
  logic [7:0]  byte_in;

  assign byte_in = {rx_shift_q[6:0], mosi_s};

  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    bytecnt_d  = bytecnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    cmd_d      = cmd_q;
    rxdata_d   = rxdata_q;
    cmd_seen_d = cmd_seen_q;
    miso_d     = miso_q;
    msg_end_d  = 1'b0;

    case (state_q)
      ST_WAIT_DESEL: begin
        miso_d = 1'b0;
        if (ssel_lvl) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        miso_d = 1'b0;
        if (ssel_fall) begin
          bitcnt_d   = '0;
          bytecnt_d  = '0;
          rx_shift_d = '0;
          rxdata_d   = '0;
          tx_shift_d = '0;
          cmd_seen_d = 1'b0;
          state_d    = ST_CMD;
        end
      end

      ST_CMD, ST_DATA, ST_OVERFLOW: begin
        if (ssel_rise) begin
          // Deselect wins over any sclk edge this cycle; a partial byte is dropped.
          msg_end_d = cmd_seen_q;
          miso_d    = 1'b0;
          bitcnt_d  = '0;
          state_d   = ST_IDLE;
        end else begin
          case (state_q)
            ST_CMD: begin
              miso_d = 1'b0;
              if (sclk_rise_v) begin
                rx_shift_d = byte_in;
                bitcnt_d   = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                  cmd_d      = byte_in;
                  cmd_seen_d = 1'b1;
                  tx_shift_d = spi_txdata_valid ? spi_txdata : 64'h0;
                  state_d    = ST_DATA;
                end
              end
            end

            ST_DATA: begin
              if (sclk_rise_v) begin
                rx_shift_d = byte_in;
                bitcnt_d   = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                  for (int i = 0; i < MAX_DATA_BYTES; i++) begin
                    if (bytecnt_q == 4'(i)) rxdata_d[63-8*i -: 8] = byte_in;
                  end
                  bytecnt_d = bytecnt_q + 4'd1;
                  if (bytecnt_q == 4'(MAX_DATA_BYTES - 1)) begin
                    state_d = ST_OVERFLOW;
                    miso_d  = 1'b0;
                  end
                end
              end else if (sclk_fall_v) begin
                // Mode 0: update on the falling edge, host samples on the rise.
                miso_d     = tx_shift_q[63];
                tx_shift_d = {tx_shift_q[62:0], 1'b0};
              end
            end

            default: begin
              miso_d = 1'b0;
            end
          endcase
        end
      end

      default: begin
        state_d = ST_WAIT_DESEL;
        miso_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_WAIT_DESEL;
      bitcnt_q   <= '0;
      bytecnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      cmd_q      <= '0;
      rxdata_q   <= '0;
      cmd_seen_q <= 1'b0;
      miso_q     <= 1'b0;
      msg_end_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      bytecnt_q  <= bytecnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      cmd_q      <= cmd_d;
      rxdata_q   <= rxdata_d;
      cmd_seen_q <= cmd_seen_d;
      miso_q     <= miso_d;
      msg_end_q  <= msg_end_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_msg_end = msg_end_q;
  assign spi_cmd     = cmd_q;
  assign spi_rxdata  = rxdata_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Purpose : directed self-checking bench for spi_slave_if.
// Latency : n/a.
// Backpressure: n/a.
module tb_spi_slave_if;
  import spi_pkg::*;

  localparam int HALF = 80;   // SPI half period = 8 clk, well under clk/6

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_sclk, spi_ssel_n, spi_mosi;
  logic        spi_miso, spi_msg_end;
  logic [7:0]  spi_cmd;
  logic [63:0] spi_rxdata;
  logic [63:0] spi_txdata;
  logic        spi_txdata_valid;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int hi_cycles = 0;
  logic prev_end = 1'b0;

  spi_slave_if #(.SYNC_STAGES(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .spi_sclk         (spi_sclk),
    .spi_ssel_n       (spi_ssel_n),
    .spi_mosi         (spi_mosi),
    .spi_miso         (spi_miso),
    .spi_msg_end      (spi_msg_end),
    .spi_cmd          (spi_cmd),
    .spi_rxdata       (spi_rxdata),
    .spi_txdata       (spi_txdata),
    .spi_txdata_valid (spi_txdata_valid)
  );

  always #5 clk = ~clk;

  // msg_end pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (spi_msg_end) hi_cycles++;
    if (spi_msg_end && !prev_end) pulse_cnt++;
    prev_end = spi_msg_end;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // Shift nbits of val (MSB first of those bits); MISO sampled just before each rise.
  task automatic spi_bits(input logic [7:0] val, input int nbits, output logic [7:0] rd);
    rd = 8'h00;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi_mosi = val[i];
      #(HALF);
      rd = {rd[6:0], spi_miso};
      spi_sclk = 1'b1;
      #(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic sel;
    spi_ssel_n = 1'b0;
    #(HALF);
  endtask

  task automatic desel;
    #(HALF);
    spi_ssel_n = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  logic [7:0]  rd;
  logic [63:0] acc;
  int          p0, h0;

  initial begin
    reset = 1'b1;
    spi_sclk = 1'b0; spi_ssel_n = 1'b1; spi_mosi = 1'b0;
    spi_txdata = 64'h0; spi_txdata_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_cmd",     {56'h0, spi_cmd}, 64'h0);
    chk("rst_rxdata",  spi_rxdata,       64'h0);
    chk("rst_msg_end", {63'h0, spi_msg_end}, 64'h0);
    chk("rst_miso",    {63'h0, spi_miso},    64'h0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // 1: full message
    p0 = pulse_cnt;
    sel();
    spi_bits(CMD_SET_KEYB_MATRIX, 8, rd);
    for (int b = 1; b <= 8; b++) spi_bits(8'(b), 8, rd);
    desel();
    chk("t1_pulses", 64'(pulse_cnt - p0), 64'd1);
    chk("t1_cmd",    {56'h0, spi_cmd}, 64'h10);
    chk("t1_rxdata", spi_rxdata, 64'h0102030405060708);

    // 2: single data byte, pulse width
    p0 = pulse_cnt; h0 = hi_cycles;
    sel();
    spi_bits(CMD_RESET, 8, rd);
    spi_bits(8'h01, 8, rd);
    desel();
    chk("t2_pulses", 64'(pulse_cnt - p0), 64'd1);
    chk("t2_width",  64'(hi_cycles - h0), 64'd1);
    chk("t2_cmd",    {56'h0, spi_cmd}, 64'h01);
    chk("t2_rxdata", spi_rxdata, 64'h0100000000000000);

    // 3: MISO readback, valid then invalid
    spi_txdata = 64'hA55A_0011_2233_4455; spi_txdata_valid = 1'b1;
    sel();
    spi_bits(CMD_SET_VIDMODE, 8, rd);
    chk("t3_miso_cmd", {56'h0, rd}, 64'h0);
    acc = 64'h0;
    for (int b = 0; b < 8; b++) begin
      spi_bits(8'hFF, 8, rd);
      acc = {acc[55:0], rd};
    end
    desel();
    chk("t3_miso_data", acc, 64'hA55A_0011_2233_4455);
    spi_txdata_valid = 1'b0;
    sel();
    spi_bits(CMD_SET_VIDMODE, 8, rd);
    acc = 64'h0;
    for (int b = 0; b < 8; b++) begin
      spi_bits(8'hFF, 8, rd);
      acc = {acc[55:0], rd};
    end
    desel();
    chk("t3_miso_invalid", acc, 64'h0);
    chk("t3_rxdata", spi_rxdata, 64'hFFFF_FFFF_FFFF_FFFF);

    // 4: cmd + 3 bits (11 total), then a 5-bit runt message
    p0 = pulse_cnt;
    sel();
    spi_bits(CMD_SET_VIDMODE, 8, rd);
    spi_bits(8'h07, 3, rd);
    desel();
    chk("t4_pulses", 64'(pulse_cnt - p0), 64'd1);
    chk("t4_cmd",    {56'h0, spi_cmd}, 64'h40);
    chk("t4_rxdata", spi_rxdata, 64'h0);
    p0 = pulse_cnt;
    sel();
    spi_bits(8'h1F, 5, rd);
    desel();
    chk("t4_runt_pulses", 64'(pulse_cnt - p0), 64'd0);
    chk("t4_runt_cmd",    {56'h0, spi_cmd}, 64'h40);

    // 5: overflow, MISO quiet past bit 64
    spi_txdata = 64'hFFFF_FFFF_FFFF_FFFF; spi_txdata_valid = 1'b1;
    p0 = pulse_cnt;
    sel();
    spi_bits(CMD_WRITE_KBBUF, 8, rd);
    acc = 64'h0;
    for (int b = 0; b < 10; b++) begin
      spi_bits(8'h11 + 8'(b), 8, rd);
      if (b < 8) acc = {acc[55:0], rd};
      else chk("t5_miso_after64", {56'h0, rd}, 64'h0);
    end
    desel();
    spi_txdata_valid = 1'b0;
    chk("t5_miso_data", acc, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t5_pulses", 64'(pulse_cnt - p0), 64'd1);
    chk("t5_rxdata", spi_rxdata, 64'h1112131415161718);

    // 6: reset mid-message
    p0 = pulse_cnt;
    sel();
    spi_bits(CMD_SET_HCTRL, 3, rd);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    spi_bits(CMD_SET_HCTRL, 5, rd);
    spi_bits(8'hAB, 8, rd);
    desel();
    chk("t6_pulses", 64'(pulse_cnt - p0), 64'd0);
    chk("t6_cmd",    {56'h0, spi_cmd}, 64'h0);
    p0 = pulse_cnt;
    sel();
    spi_bits(CMD_SET_KEYB_MATRIX, 8, rd);
    for (int b = 1; b <= 8; b++) spi_bits(8'(b), 8, rd);
    desel();
    chk("t6_after_pulses", 64'(pulse_cnt - p0), 64'd1);
    chk("t6_after_cmd",    {56'h0, spi_cmd}, 64'h10);
    chk("t6_after_rxdata", spi_rxdata, 64'h0102030405060708);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
